// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, default sizes and the wrap-around priority search
// for the round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {IDLE, BUSY} state_t;

   localparam int N_REQ_DEF  = 4;
   localparam int DATA_W_DEF = 8;

   // First set bit of req[n-1:0] searching ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
   function automatic logic [3:0] next_set(input logic [15:0] req, input logic [3:0] ptr, input int n);
      logic [4:0] idx;
      logic       found;
      next_set = '0;
      found    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = 5'(ptr) + 5'(i);
         if (idx >= 5'(n)) idx = idx - 5'(n);
         if (!found && i < n && req[idx[3:0]]) begin
            next_set = idx[3:0];
            found    = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// mux_n: N_REQ x DATA_W combinational lane select with a zero-output enable.
module mux_n
   import mux_arb_pkg::*;
#(
   parameter  int N_REQ  = N_REQ_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   localparam int SEL_W  = $clog2(N_REQ)
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic                    en,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   output logic [DATA_W-1:0]       out
);

   logic [DATA_W-1:0] lane [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      assign lane[i] = in_data[i*DATA_W +: DATA_W];
   end

   assign out = en ? lane[sel] : '0;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner arbitration for a shared N:1 data mux.
// Define MUX_ARB_TIMEOUT_EN to enable forced revoke after MAX_HOLD busy cycles.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int N_REQ    = N_REQ_DEF,
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int MAX_HOLD = 16,
   localparam int SEL_W    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   output logic [N_REQ-1:0]        gnt,
   output logic [SEL_W-1:0]        sel,
   output logic                    busy,
   output logic [DATA_W-1:0]       OUT,
   output logic                    revoke
);

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d, win;
   logic [15:0]       req_w;
   logic [3:0]        ptr_w;
   logic              force_rel, rel;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             revoke_q, revoke_d;

   // Only revoke when someone else is actually waiting for the path.
   assign force_rel = (cnt_q == CNT_W'(MAX_HOLD - 1)) && |(req & ~gnt_q);

   always_comb begin
      cnt_d    = cnt_q;
      revoke_d = 1'b0;
      if (state_q == IDLE) cnt_d = '0;
      else if (rel) begin
         cnt_d    = '0;
         revoke_d = req[sel_q];
      end else if (cnt_q != CNT_W'(MAX_HOLD)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         revoke_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         revoke_q <= revoke_d;
      end
   end

   assign revoke = revoke_q;
`else
   assign force_rel = 1'b0;
   assign revoke    = (MAX_HOLD < 0);
`endif

   assign rel = !req[sel_q] || force_rel;

   always_comb begin
      req_w              = '0;
      req_w[N_REQ-1:0]   = req;
      ptr_w              = '0;
      ptr_w[SEL_W-1:0]   = ptr_q;
      win                = SEL_W'(next_set(req_w, ptr_w, N_REQ));
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (state_q == IDLE) begin
         if (|req) begin
            state_d = BUSY;
            sel_d   = win;
            gnt_d   = N_REQ'(1) << win;
         end
      end else if (rel) begin
         // Releasing owner drops to lowest priority.
         state_d = IDLE;
         gnt_d   = '0;
         sel_d   = '0;
         ptr_d   = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = (state_q == BUSY);

   mux_n #(.N_REQ(N_REQ), .DATA_W(DATA_W)) u_mux (
      .sel     (sel_q),
      .en      (busy),
      .in_data (in_data),
      .out     (OUT)
   );

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed checks of grant order, data routing, reset and timeout.
module tb_mux_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        busy;
   logic [7:0]  OUT;
   logic        revoke;
   int          tests = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   mux_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .in_data (in_data),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .OUT     (OUT),
      .revoke  (revoke)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      step(3);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_out", 32'(OUT), 32'h0);
      chk("rst_revoke", 32'(revoke), 32'h0);
      rst_n = 1'b1;
      step();
      chk("idle_no_req", 32'(busy), 32'h0);

      req = 4'b0100;
      step();
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_sel", 32'(sel), 32'h2);
      chk("single_out", 32'(OUT), 32'hA5);
      step(2);
      chk("single_hold", 32'(gnt), 32'h4);
      req = 4'b0000;
      step();
      chk("single_rel_busy", 32'(busy), 32'h0);
      chk("single_rel_out", 32'(OUT), 32'h0);

      req = 4'b0011;
      step();
      chk("wrap_gnt0", 32'(gnt), 32'h1);
      chk("wrap_out0", 32'(OUT), 32'h11);
      req = 4'b0010;
      step();
      chk("wrap_bubble", 32'(busy), 32'h0);
      step();
      chk("wrap_gnt1", 32'(gnt), 32'h2);
      chk("wrap_out1", 32'(OUT), 32'h22);

      req = 4'b1010;
      step();
      chk("nonowner_gnt_a", 32'(gnt), 32'h2);
      in_data[15:8] = 8'h77;
      #1;
      chk("nonowner_out_follow", 32'(OUT), 32'h77);
      req = 4'b0010;
      step();
      chk("nonowner_gnt_b", 32'(gnt), 32'h2);
      req = 4'b1010;
      step();
      chk("nonowner_gnt_c", 32'(gnt), 32'h2);
      in_data[15:8] = 8'h22;

      req = 4'b1111;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'h0);
      chk("midrst_sel", 32'(sel), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_out", 32'(OUT), 32'h0);
      rst_n = 1'b1;
      step();

      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
         chk($sformatf("rr_sel_%0d", k), 32'(sel), 32'(k % 4));
         step();
         chk($sformatf("rr_hold_%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
         req = 4'b1111 & ~(4'b0001 << (k % 4));
         step();
         chk($sformatf("rr_bubble_%0d", k), 32'(busy), 32'h0);
         req = 4'b1111;
         step();
      end
      chk("rr_final", 32'(gnt), 32'h2);

      req = 4'b0000;
      step();
      req = 4'b0001;
      step();
      chk("to_gnt0", 32'(gnt), 32'h1);
      req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("to_hold_%0d", k), 32'(gnt), 32'h1);
         chk($sformatf("to_norev_%0d", k), 32'(revoke), 32'h0);
      end
      step();
      chk("to_revoke", 32'(revoke), 32'h1);
      chk("to_rev_gnt", 32'(gnt), 32'h0);
      step();
      chk("to_rev_pulse", 32'(revoke), 32'h0);
      chk("to_next_gnt", 32'(gnt), 32'h2);
      req = 4'b0010;
      step(20);
      chk("to_alone_gnt", 32'(gnt), 32'h2);
      chk("to_alone_rev", 32'(revoke), 32'h0);
`else
      step(20);
      chk("noto_hold", 32'(gnt), 32'h1);
      chk("noto_revoke", 32'(revoke), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
